// File: rtl/cpu_trace_writer.sv
// Retired-write event serializer: each accepted event becomes one ASCII trace
// record, emitted one character per out_valid/out_ready beat.
module cpu_trace_writer #(
  parameter int unsigned GAP       = 0,
  parameter logic [7:0]  IDLE_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_mem,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  localparam int unsigned TIME_W = 14;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned GAP_W  = (GAP < 2) ? 1 : $clog2(GAP);

  localparam logic [TIME_W-1:0] TIME_MAX = TIME_W'(9999);

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;

  typedef enum logic [4:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
    S_REG, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_GAP
  } state_t;

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Shift-and-add-3 binary to BCD; input is already saturated to 4 digits.
  function automatic logic [BCD_W-1:0] to_bcd(input logic [TIME_W-1:0] bin);
    logic [BCD_W+TIME_W-1:0] sr;
    sr = {{BCD_W{1'b0}}, bin};
    for (int i = 0; i < int'(TIME_W); i++) begin
      for (int d = 0; d < 4; d++) begin
        if (sr[TIME_W+4*d +: 4] >= 4'd5) sr[TIME_W+4*d +: 4] = sr[TIME_W+4*d +: 4] + 4'd3;
      end
      sr = sr << 1;
    end
    return sr[BCD_W+TIME_W-1:TIME_W];
  endfunction

  state_t              state;
  logic                mem_q;
  logic [BCD_W-1:0]    tbcd_q;
  logic [2:0]          tcnt_q;
  logic [WORD_W-1:0]   pc_q;
  logic [WORD_W-1:0]   addr_q;
  logic [WORD_W-1:0]   data_q;
  logic [1:0]          reg_tens_q;
  logic [3:0]          reg_ones_q;
  logic [WORD_W-1:0]   sh_q;
  logic [2:0]          cnt_q;
  logic [GAP_W-1:0]    gap_cnt;

  logic [TIME_W-1:0]   time_sat_c;
  logic [BCD_W-1:0]    bcd_c;
  logic [BCD_W-1:0]    bcd_al_c;
  logic [2:0]          tlen_c;
  logic [1:0]          reg_tens_c;
  logic [3:0]          reg_ones_c;
  logic                beat_c;

  assign beat_c = out_valid & out_ready;

  // Time digits are left-aligned at accept so the record just shifts them out.
  always_comb begin
    time_sat_c = (in_time > TIME_MAX) ? TIME_MAX : in_time;
    bcd_c      = to_bcd(time_sat_c);
    tlen_c     = 3'd1;
    bcd_al_c   = bcd_c << 12;
    if (bcd_c[15:12] != 4'd0) begin
      tlen_c   = 3'd4;
      bcd_al_c = bcd_c;
    end else if (bcd_c[11:8] != 4'd0) begin
      tlen_c   = 3'd3;
      bcd_al_c = bcd_c << 4;
    end else if (bcd_c[7:4] != 4'd0) begin
      tlen_c   = 3'd2;
      bcd_al_c = bcd_c << 8;
    end
  end

  always_comb begin
    reg_tens_c = 2'd0;
    reg_ones_c = 4'(in_reg);
    if (in_reg >= 5'd30) begin
      reg_tens_c = 2'd3;
      reg_ones_c = 4'(in_reg - 5'd30);
    end else if (in_reg >= 5'd20) begin
      reg_tens_c = 2'd2;
      reg_ones_c = 4'(in_reg - 5'd20);
    end else if (in_reg >= 5'd10) begin
      reg_tens_c = 2'd1;
      reg_ones_c = 4'(in_reg - 5'd10);
    end
  end

  // Record sequencer; char always holds the character of the current state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      char       <= IDLE_CHAR;
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      gap_cnt    <= '0;
      mem_q      <= 1'b0;
      tbcd_q     <= '0;
      tcnt_q     <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      reg_tens_q <= '0;
      reg_ones_q <= '0;
      sh_q       <= '0;
      cnt_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid && in_ready) begin
          mem_q      <= in_mem;
          tbcd_q     <= bcd_al_c;
          tcnt_q     <= tlen_c;
          pc_q       <= in_pc;
          addr_q     <= in_addr;
          data_q     <= in_data;
          reg_tens_q <= reg_tens_c;
          reg_ones_q <= reg_ones_c;
          state      <= S_CARET;
          char       <= CH_CARET;
          out_valid  <= 1'b1;
          in_ready   <= 1'b0;
          busy       <= 1'b1;
        end
        S_CARET: if (beat_c) begin
          state  <= S_TIME;
          char   <= dec_char(tbcd_q[15:12]);
          tbcd_q <= tbcd_q << 4;
          tcnt_q <= tcnt_q - 3'd1;
        end
        S_TIME: if (beat_c) begin
          if (tcnt_q == 3'd0) begin
            state <= S_AT;
            char  <= CH_AT;
          end else begin
            char   <= dec_char(tbcd_q[15:12]);
            tbcd_q <= tbcd_q << 4;
            tcnt_q <= tcnt_q - 3'd1;
          end
        end
        S_AT: if (beat_c) begin
          state <= S_PC;
          char  <= hex_char(pc_q[31:28]);
          sh_q  <= pc_q << 4;
          cnt_q <= 3'd7;
        end
        S_PC: if (beat_c) begin
          if (cnt_q == 3'd0) begin
            state <= S_COLON;
            char  <= CH_COLON;
          end else begin
            char  <= hex_char(sh_q[31:28]);
            sh_q  <= sh_q << 4;
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_COLON: if (beat_c) begin
          state <= S_SP1;
          char  <= CH_SP;
        end
        S_SP1: if (beat_c) begin
          state <= S_SIGIL;
          char  <= mem_q ? CH_STAR : CH_DOLLAR;
        end
        S_SIGIL: if (beat_c) begin
          if (mem_q) begin
            state <= S_ADDR;
            char  <= hex_char(addr_q[31:28]);
            sh_q  <= addr_q << 4;
            cnt_q <= 3'd7;
          end else if (reg_tens_q != 2'd0) begin
            state <= S_REG;
            char  <= dec_char({2'b00, reg_tens_q});
            cnt_q <= 3'd1;
          end else begin
            state <= S_REG;
            char  <= dec_char(reg_ones_q);
            cnt_q <= 3'd0;
          end
        end
        S_REG: if (beat_c) begin
          if (cnt_q == 3'd0) begin
            state <= S_SP2;
            char  <= CH_SP;
          end else begin
            char  <= dec_char(reg_ones_q);
            cnt_q <= 3'd0;
          end
        end
        S_ADDR: if (beat_c) begin
          if (cnt_q == 3'd0) begin
            state <= S_SP2;
            char  <= CH_SP;
          end else begin
            char  <= hex_char(sh_q[31:28]);
            sh_q  <= sh_q << 4;
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_SP2: if (beat_c) begin
          state <= S_LT;
          char  <= CH_LT;
        end
        S_LT: if (beat_c) begin
          state <= S_EQ;
          char  <= CH_EQ;
        end
        S_EQ: if (beat_c) begin
          state <= S_SP3;
          char  <= CH_SP;
        end
        S_SP3: if (beat_c) begin
          state <= S_DATA;
          char  <= hex_char(data_q[31:28]);
          sh_q  <= data_q << 4;
          cnt_q <= 3'd7;
        end
        S_DATA: if (beat_c) begin
          if (cnt_q == 3'd0) begin
            state <= S_HASH;
            char  <= CH_HASH;
          end else begin
            char  <= hex_char(sh_q[31:28]);
            sh_q  <= sh_q << 4;
            cnt_q <= cnt_q - 3'd1;
          end
        end
        // The accepting IDLE cycle is the last idle beat, so GAP holds GAP-1 cycles.
        S_HASH: if (beat_c) begin
          out_valid <= 1'b0;
          char      <= IDLE_CHAR;
          if (GAP > 1) begin
            state   <= S_GAP;
            gap_cnt <= GAP_W'(GAP - 1);
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_W'(1)) begin
            state    <= S_IDLE;
            gap_cnt  <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          char      <= IDLE_CHAR;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_writer.sv
// Randomized bench for cpu_trace_writer: expected records are formatted
// directly from the event fields and compared character by character.
module tb_cpu_trace_writer;

  localparam logic [7:0] IDLE_CHAR = 8'h00;

  typedef struct {
    bit          mem;
    logic [13:0] t;
    logic [31:0] pc;
    logic [4:0]  rg;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        in_valid;
  logic        in_mem;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        out_ready;

  logic        iv0, iv3, ir0, ir3, ov0, ov3, busy0, busy3;
  logic [7:0]  ch0, ch3;
  logic        in_ready_m, out_valid_m, busy_m;
  logic [7:0]  char_m;

  assign iv0         = in_valid & ~sel;
  assign iv3         = in_valid & sel;
  assign in_ready_m  = sel ? ir3 : ir0;
  assign out_valid_m = sel ? ov3 : ov0;
  assign busy_m      = sel ? busy3 : busy0;
  assign char_m      = sel ? ch3 : ch0;

  cpu_trace_writer #(.GAP(0), .IDLE_CHAR(IDLE_CHAR)) dut0 (
    .clk(clk), .reset(rst_n), .in_valid(iv0), .in_ready(ir0), .in_mem(in_mem),
    .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg), .in_addr(in_addr),
    .in_data(in_data), .char(ch0), .out_valid(ov0), .out_ready(out_ready), .busy(busy0)
  );

  cpu_trace_writer #(.GAP(3), .IDLE_CHAR(IDLE_CHAR)) dut3 (
    .clk(clk), .reset(rst_n), .in_valid(iv3), .in_ready(ir3), .in_mem(in_mem),
    .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg), .in_addr(in_addr),
    .in_data(in_data), .char(ch3), .out_valid(ov3), .out_ready(out_ready), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  ev_t   evq[$];
  string recq[$];
  int    gapq[$];
  bit    stall_mode = 1'b0;
  string cur_rec = "";
  bit    in_rec = 1'b0;
  bit    have_prev = 1'b0;
  int    idle_run = 0;
  bit    stalled = 1'b0;
  logic [7:0] prev_ch = 8'h00;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic ev_t mk_ev(input bit mem, input logic [13:0] t, input logic [31:0] pc,
                                input logic [4:0] rg, input logic [31:0] addr,
                                input logic [31:0] data);
    ev_t e;
    e.mem = mem; e.t = t; e.pc = pc; e.rg = rg; e.addr = addr; e.data = data;
    return e;
  endfunction

  // Reference record text built straight from the trace format.
  function automatic string expect_str(input ev_t e);
    int unsigned ts;
    ts = (e.t > 14'd9999) ? 9999 : 32'(e.t);
    if (e.mem) return $sformatf("^%0d@%08h: *%08h <= %08h#", ts, e.pc, e.addr, e.data);
    return $sformatf("^%0d@%08h: $%0d <= %08h#", ts, e.pc, e.rg, e.data);
  endfunction

  task automatic cmp_str(input string tag, input string got, input string exp);
    check({tag, "_len"}, 64'(got.len()), 64'(exp.len()));
    for (int i = 0; i < exp.len() && i < got.len(); i++)
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
  endtask

  task automatic wait_rec(output string s);
    int g;
    g = 0;
    while (recq.size() == 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (recq.size() == 0) begin
      check("record_timeout", 64'(recq.size()), 64'(1));
      s = "";
    end else begin
      s = recq.pop_front();
    end
  endtask

  task automatic run_one(input ev_t e, input string tag);
    string got;
    evq.push_back(e);
    wait_rec(got);
    cmp_str(tag, got, expect_str(e));
  endtask

  // Event driver: holds in_valid until accepted, then scrambles the fields.
  initial begin : driver
    bit  acc_pending;
    ev_t e;
    acc_pending = 1'b0;
    in_valid = 1'b0; in_mem = 1'b0; in_time = '0; in_pc = '0;
    in_reg = '0; in_addr = '0; in_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_valid    = 1'b0;
        acc_pending = 1'b0;
      end else begin
        if (acc_pending) begin
          in_valid    = 1'b0;
          acc_pending = 1'b0;
          in_mem  = 1'($urandom);
          in_time = 14'($urandom);
          in_pc   = $urandom;
          in_reg  = 5'($urandom);
          in_addr = $urandom;
          in_data = $urandom;
        end
        if (!in_valid && evq.size() > 0) begin
          e       = evq.pop_front();
          in_mem  = e.mem;
          in_time = e.t;
          in_pc   = e.pc;
          in_reg  = e.rg;
          in_addr = e.addr;
          in_data = e.data;
          in_valid = 1'b1;
        end
        if (in_valid && in_ready_m) acc_pending = 1'b1;
      end
    end
  end

  // Output monitor: collects beats into records and checks stall/idle rules.
  initial begin : monitor
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_rec = ""; in_rec = 1'b0; stalled = 1'b0;
        have_prev = 1'b0; idle_run = 0; out_ready = 1'b1;
      end else begin
        if (stalled) begin
          check("stall_valid_hold", 64'(out_valid_m), 64'(1));
          check("stall_char_hold", 64'(char_m), 64'(prev_ch));
        end
        if (!out_valid_m) begin
          check("idle_char", 64'(char_m), 64'(IDLE_CHAR));
          if (in_rec) check("valid_contiguous", 64'(out_valid_m), 64'(1));
          idle_run++;
        end else if (!in_rec) begin
          in_rec = 1'b1;
          if (have_prev) gapq.push_back(idle_run);
        end
        out_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        if (out_valid_m && out_ready) begin
          cur_rec = $sformatf("%s%c", cur_rec, char_m);
          if (char_m == 8'h23) begin
            recq.push_back(cur_rec);
            cur_rec   = "";
            in_rec    = 1'b0;
            have_prev = 1'b1;
            idle_run  = 0;
          end
        end
        stalled = out_valid_m & ~out_ready;
        prev_ch = char_m;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    ev_t   e, e2;
    string got, got2, s_ref1;
    int    cnt, g;
    sel = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid_m), 64'(0));
    check("rst_char", 64'(char_m), 64'(IDLE_CHAR));
    check("rst_in_ready", 64'(in_ready_m), 64'(1));
    check("rst_busy", 64'(busy_m), 64'(0));
    check("rst_gap_in_ready", 64'(ir3), 64'(1));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    e = mk_ev(1'b0, 14'd1234, 32'h0000_3000, 5'd31, 32'h0, 32'hdeadbeef);
    evq.push_back(e);
    g = 0;
    while (in_ready_m && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("busy_in_record", 64'(busy_m), 64'(1));
    cnt = 0;
    while (!in_ready_m && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check("in_ready_low_cycles", 64'(cnt), 64'(32));
    check("busy_after_record", 64'(busy_m), 64'(0));
    wait_rec(got);
    cmp_str("reg_rec", got, expect_str(e));
    cmp_str("reg_rec_lit", got, "^1234@00003000: $31 <= deadbeef#");
    s_ref1 = got;

    e2 = mk_ev(1'b1, 14'd0, 32'h0000_400c, 5'd3, 32'h0000_1ff8, 32'h0000_000a);
    evq.push_back(e2);
    wait_rec(got);
    cmp_str("mem_rec_lit", got, "^0@0000400c: *00001ff8 <= 0000000a#");

    run_one(mk_ev(1'b0, 14'd10000, 32'h1000, 5'd1, 32'h0, 32'h1), "time_sat");
    run_one(mk_ev(1'b1, 14'd16383, 32'h2000, 5'd1, 32'h4, 32'h2), "time_max");
    run_one(mk_ev(1'b0, 14'd7, 32'h1004, 5'd0, 32'h0, 32'h12345678), "time7_reg0");
    run_one(mk_ev(1'b0, 14'd99, 32'hffff_fffc, 5'd9, 32'h0, 32'h0), "reg9");
    run_one(mk_ev(1'b0, 14'd100, 32'h0000_0001, 5'd10, 32'h0, 32'hffffffff), "reg10");

    stall_mode = 1'b1;
    evq.push_back(e);
    wait_rec(got);
    cmp_str("backpressure", got, s_ref1);

    for (int k = 0; k < 20; k++) begin
      ev_t r;
      r = mk_ev(1'($urandom), 14'($urandom), $urandom, 5'($urandom), $urandom, $urandom);
      if (k % 4 == 0) r.t = 14'($urandom_range(9990, 16383));
      stall_mode = (k % 2) == 1;
      run_one(r, $sformatf("rand%0d", k));
    end
    stall_mode = 1'b0;

    repeat (2) @(negedge clk);
    gapq.delete();
    have_prev = 1'b0;
    evq.push_back(e);
    evq.push_back(e2);
    wait_rec(got);
    wait_rec(got2);
    cmp_str("b2b0_a", got, expect_str(e));
    cmp_str("b2b0_b", got2, expect_str(e2));
    check("b2b0_gap_count", 64'(gapq.size()), 64'(1));
    if (gapq.size() > 0) check("b2b0_gap_len", 64'(gapq[0]), 64'(1));

    sel = 1'b1;
    repeat (2) @(negedge clk);
    gapq.delete();
    have_prev = 1'b0;
    evq.push_back(e);
    evq.push_back(e2);
    wait_rec(got);
    wait_rec(got2);
    cmp_str("gap3_a", got, expect_str(e));
    cmp_str("gap3_b", got2, expect_str(e2));
    check("gap3_count", 64'(gapq.size()), 64'(1));
    if (gapq.size() > 0) check("gap3_len", 64'(gapq[0]), 64'(3));
    repeat (2) @(negedge clk);
    sel = 1'b0;
    repeat (2) @(negedge clk);

    evq.push_back(mk_ev(1'b0, 14'd4321, 32'h0000_8000, 5'd17, 32'h0, 32'hcafef00d));
    g = 0;
    while (cur_rec.len() < 9 && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("pre_reset_valid", 64'(out_valid_m), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid_m), 64'(0));
    check("async_rst_char", 64'(char_m), 64'(IDLE_CHAR));
    check("async_rst_in_ready", 64'(in_ready_m), 64'(1));
    check("async_rst_busy", 64'(busy_m), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_no_record", 64'(recq.size()), 64'(0));
    run_one(mk_ev(1'b1, 14'd55, 32'h0000_0100, 5'd2, 32'h0000_0200, 32'h0badf00d), "post_reset");
    run_one(mk_ev(1'b0, 14'd9999, 32'h0000_0104, 5'd20, 32'h0, 32'h00000001), "post_reset_reg");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
